// File: rtl/alu_share_arbiter_pkg.sv
// Purpose: shared ALU definitions (opcodes, sequencer states, request payload).
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: ALU_FWD/ADD/OR/AND opcode constants, state_t (IDLE/WAIT/RESP),
//           alu_req_t packed request payload.
package alu_defs;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] operand1;
    logic [7:0] operand2;
  } alu_req_t;

endpackage

// File: rtl/alu_share_grant.sv
// Purpose: grant selection between the two ALU requesters, plus LAST_GRANT pointer.
// Latency: combinational grant; pointer updates on the accepting edge.
// Backpressure: none of its own; the sequencer only uses the grant while idle.
// Macro: ALU_SHARE_RR_EN selects round-robin; undefined gives fixed priority to port 0.
// Ports: clk, reset (async, active-high), req0_valid, req1_valid, take (handshake),
//        grant_vld (some request present), grant_id (winning port).
module alu_share_grant (
  input  logic clk,
  input  logic reset,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic take,
  output logic grant_vld,
  output logic grant_id
);

  assign grant_vld = req0_valid | req1_valid;

`ifdef ALU_SHARE_RR_EN
  // Points at the port served last; resets to 1 so port 0 wins first.
  logic last_grant;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (take) begin
      last_grant <= grant_id;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is absent.
  assign grant_id = req1_valid & ~req0_valid;

  logic unused_rr;
  assign unused_rr = &{1'b0, clk, reset, take};
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose: shares one 8-bit ALU between decode (port 0) and aux (port 1) requesters.
// Latency: result captured SETTLE_CYCLES edges after the accepting edge; issues spaced >= SETTLE_CYCLES+2.
// Backpressure: response held until rsp_ready; no request is accepted while busy.
// Macro: ALU_SHARE_RR_EN (tested only inside alu_share_grant) enables round-robin.
// Ports: req0_*/req1_* valid/ready request ports, alu_* registered ALU inputs and
//        raw ALU outputs, rsp_* held response (valid/ready), busy = not IDLE.
module alu_share_arbiter
  import alu_defs::*;
#(
  parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_operand1,
  input  logic [7:0] req0_operand2,
  input  logic [2:0] req0_alu_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_operand1,
  input  logic [7:0] req1_operand2,
  input  logic [2:0] req1_alu_op,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       grant_vld;
  logic       grant_id;
  logic       take;
  alu_req_t   sel_req;

  alu_share_grant u_grant (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .take       (take),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  // Payload of the winning port; only sampled on the handshake edge.
  assign sel_req = grant_id ? '{op: req1_alu_op, operand1: req1_operand1, operand2: req1_operand2}
                            : '{op: req0_alu_op, operand1: req0_operand1, operand2: req0_operand2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // READY is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        take       = grant_vld & ~reset;
        req0_ready = take & ~grant_id;
        req1_ready = take & grant_id;
        if (take) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE costs one bubble before the next grant.
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU input registers deliberately keep their value after the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_operand1 <= 8'h00;
      alu_operand2 <= 8'h00;
      alu_op       <= ALU_FWD;
      settle_cnt   <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 8'h00;
      rsp_zero     <= 1'b0;
    end else begin
      if (take) begin
        alu_operand1 <= sel_req.operand1;
        alu_operand2 <= sel_req.operand2;
        alu_op       <= sel_req.op;
        rsp_id       <= grant_id;
        settle_cnt   <= SETTLE_LOAD;
      end else if (state == WAIT && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      if (state == WAIT && settle_cnt == 4'd0) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic reset;

  // index 0: SETTLE_CYCLES=1 instance, index 1: SETTLE_CYCLES=3 instance
  logic       r0_v[2], r1_v[2], r0_rdy[2], r1_rdy[2];
  logic [7:0] r0_a[2], r0_b[2], r1_a[2], r1_b[2];
  logic [2:0] r0_op[2], r1_op[2], alu_op[2];
  logic [7:0] alu_a[2], alu_b[2], alu_res[2], rsp_res[2];
  logic       alu_z[2], rsp_v[2], rsp_rdy[2], rsp_id[2], rsp_z[2], busy[2];

  typedef struct {
    bit       id;
    bit [7:0] res;
    bit       z;
  } exp_t;

  exp_t exp_q0[$], exp_q1[$];
  time  hs_q0[$], hs_q1[$];
  int   hs_cnt[2];
  bit   rsp_v_q[2];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   contend = 1'b0;
  int   r1_rdy_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0_v[0]), .req0_ready(r0_rdy[0]), .req0_operand1(r0_a[0]),
    .req0_operand2(r0_b[0]), .req0_alu_op(r0_op[0]),
    .req1_valid(r1_v[0]), .req1_ready(r1_rdy[0]), .req1_operand1(r1_a[0]),
    .req1_operand2(r1_b[0]), .req1_alu_op(r1_op[0]),
    .alu_operand1(alu_a[0]), .alu_operand2(alu_b[0]), .alu_op(alu_op[0]),
    .alu_result(alu_res[0]), .alu_zero(alu_z[0]),
    .rsp_valid(rsp_v[0]), .rsp_ready(rsp_rdy[0]), .rsp_id(rsp_id[0]),
    .rsp_result(rsp_res[0]), .rsp_zero(rsp_z[0]), .busy(busy[0])
  );

  alu_share_arbiter #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(r0_v[1]), .req0_ready(r0_rdy[1]), .req0_operand1(r0_a[1]),
    .req0_operand2(r0_b[1]), .req0_alu_op(r0_op[1]),
    .req1_valid(r1_v[1]), .req1_ready(r1_rdy[1]), .req1_operand1(r1_a[1]),
    .req1_operand2(r1_b[1]), .req1_alu_op(r1_op[1]),
    .alu_operand1(alu_a[1]), .alu_operand2(alu_b[1]), .alu_op(alu_op[1]),
    .alu_result(alu_res[1]), .alu_zero(alu_z[1]),
    .rsp_valid(rsp_v[1]), .rsp_ready(rsp_rdy[1]), .rsp_id(rsp_id[1]),
    .rsp_result(rsp_res[1]), .rsp_zero(rsp_z[1]), .busy(busy[1])
  );

  // Stand-in for the parent's ALU.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a | b;
      3'b011:  return a & b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res[0] = alu_f(alu_op[0], alu_a[0], alu_b[0]);
  assign alu_res[1] = alu_f(alu_op[1], alu_a[1], alu_b[1]);
  assign alu_z[0]   = (alu_res[0] == 8'h00);
  assign alu_z[1]   = (alu_res[1] == 8'h00);

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int u, input bit id, input bit [7:0] res, input bit z);
    exp_t e;
    e.id = id; e.res = res; e.z = z;
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Handshake recorder: computes when the response must first be visible.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if ((r0_v[u] && r0_rdy[u]) || (r1_v[u] && r1_rdy[u])) begin
        hs_cnt[u]++;
        if (u == 0) hs_q0.push_back($time + 10 * settle_of(u) + 5);
        else        hs_q1.push_back($time + 10 * settle_of(u) + 5);
      end
    end
  end

  task automatic mon(input int u);
    exp_t e;
    time  t;
    bit   have;
    if (rsp_v[u] && !rsp_v_q[u]) begin
      have = (u == 0) ? (hs_q0.size() > 0) : (hs_q1.size() > 0);
      if (!have) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_rsp u%0d: rsp_valid high with no issue at %0t", u, $time);
      end else begin
        t = (u == 0) ? hs_q0.pop_front() : hs_q1.pop_front();
        chk($sformatf("rsp_latency_u%0d", u), int'($time), int'(t));
      end
    end
    if (rsp_v[u] && rsp_rdy[u]) begin
      have = (u == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) begin
        n_cmp++; n_fail++;
        $display("FAIL extra_rsp u%0d: got id %0d result 0x%0h, expected none", u, rsp_id[u], rsp_res[u]);
      end else begin
        e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("rsp_id_u%0d", u), int'(rsp_id[u]), int'(e.id));
        chk($sformatf("rsp_result_u%0d", u), int'(rsp_res[u]), int'(e.res));
        chk($sformatf("rsp_zero_u%0d", u), int'(rsp_z[u]), int'(e.z));
      end
    end
    rsp_v_q[u] = rsp_v[u];
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
    if (contend && r1_rdy[0]) r1_rdy_cnt++;
  end

  task automatic drive(input int u, input int port, input bit v, input bit [2:0] op,
                       input bit [7:0] a, input bit [7:0] b);
    if (port == 0) begin
      r0_v[u] = v; r0_op[u] = op; r0_a[u] = a; r0_b[u] = b;
    end else begin
      r1_v[u] = v; r1_op[u] = op; r1_a[u] = a; r1_b[u] = b;
    end
  endtask

  task automatic wait_hs(input int u, input int target);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (hs_cnt[u] < target && n < 20);
    if (hs_cnt[u] < target) begin
      n_cmp++; n_fail++;
      $display("FAIL hs_timeout u%0d: got %0d handshakes, expected %0d", u, hs_cnt[u], target);
    end
  endtask

  task automatic wait_idle(input int u);
    int  n = 0;
    bit  done;
    do begin
      @(posedge clk); #1; n++;
      done = !busy[u] && !rsp_v[u] && ((u == 0) ? exp_q0.size() == 0 : exp_q1.size() == 0);
    end while (!done && n < 50);
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout u%0d: busy %0d rsp_valid %0d, expected both 0", u, busy[u], rsp_v[u]);
    end
  endtask

  task automatic chk_reset_vals(input int u, input string tag);
    chk({tag, "_req0_ready"}, int'(r0_rdy[u]), 0);
    chk({tag, "_req1_ready"}, int'(r1_rdy[u]), 0);
    chk({tag, "_alu_operand1"}, int'(alu_a[u]), 0);
    chk({tag, "_alu_operand2"}, int'(alu_b[u]), 0);
    chk({tag, "_alu_op"}, int'(alu_op[u]), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_v[u]), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id[u]), 0);
    chk({tag, "_rsp_result"}, int'(rsp_res[u]), 0);
    chk({tag, "_rsp_zero"}, int'(rsp_z[u]), 0);
    chk({tag, "_busy"}, int'(busy[u]), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      drive(u, 0, 1'b1, 3'b001, 8'h11, 8'h22);  // valid held during reset: READY must stay 0
      drive(u, 1, 1'b1, 3'b001, 8'h33, 8'h44);
      rsp_rdy[u] = 1'b1;
      hs_cnt[u]  = 0;
      rsp_v_q[u] = 1'b0;
    end
    #12;
    for (int u = 0; u < 2; u++) chk_reset_vals(u, $sformatf("reset_u%0d", u));
    for (int u = 0; u < 2; u++) begin
      drive(u, 0, 1'b0, 3'b000, 8'h00, 8'h00);
      drive(u, 1, 1'b0, 3'b000, 8'h00, 8'h00);
    end
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // single request: ADD 05+03
    push_exp(0, 1'b0, 8'h08, 1'b0);
    drive(0, 0, 1'b1, 3'b001, 8'h05, 8'h03);
    wait_hs(0, 1);
    drive(0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    wait_idle(0);

    // zero flag: AND F0&0F on port 1
    push_exp(0, 1'b1, 8'h00, 1'b1);
    drive(0, 1, 1'b1, 3'b011, 8'hF0, 8'h0F);
    wait_hs(0, 2);
    drive(0, 1, 1'b0, 3'b000, 8'h00, 8'h00);
    wait_idle(0);

    // opcode 1xx forwarded unchanged, ALU yields 0
    push_exp(0, 1'b1, 8'h00, 1'b1);
    drive(0, 1, 1'b1, 3'b101, 8'h12, 8'h34);
    wait_hs(0, 3);
    chk("op1xx_alu_op", int'(alu_op[0]), 5);
    chk("op1xx_alu_operand1", int'(alu_a[0]), 8'h12);
    drive(0, 1, 1'b0, 3'b000, 8'h00, 8'h00);
    wait_idle(0);

    // contention: both ports valid through 4 issues
`ifdef ALU_SHARE_RR_EN
    push_exp(0, 1'b0, 8'h11, 1'b0);
    push_exp(0, 1'b1, 8'h22, 1'b0);
    push_exp(0, 1'b0, 8'h11, 1'b0);
    push_exp(0, 1'b1, 8'h22, 1'b0);
`else
    for (int i = 0; i < 4; i++) push_exp(0, 1'b0, 8'h11, 1'b0);
`endif
    contend = 1'b1;
    drive(0, 0, 1'b1, 3'b001, 8'h10, 8'h01);
    drive(0, 1, 1'b1, 3'b010, 8'h20, 8'h02);
    wait_hs(0, 7);
    drive(0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    drive(0, 1, 1'b0, 3'b000, 8'h00, 8'h00);
    contend = 1'b0;
    wait_idle(0);
`ifdef ALU_SHARE_RR_EN
    chk("contend_req1_ready_cycles", r1_rdy_cnt, 2);
`else
    chk("contend_req1_ready_cycles", r1_rdy_cnt, 0);
`endif

    // backpressure: OR A0|0A held for 5 cycles
    rsp_rdy[0] = 1'b0;
    push_exp(0, 1'b0, 8'hAA, 1'b0);
    drive(0, 0, 1'b1, 3'b010, 8'hA0, 8'h0A);
    wait_hs(0, 8);
    drive(0, 1, 1'b1, 3'b001, 8'h01, 8'h01);  // both ports waiting: neither may be READY
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", int'(rsp_v[0]), 1);
      chk("bp_rsp_result", int'(rsp_res[0]), 8'hAA);
      chk("bp_busy", int'(busy[0]), 1);
      chk("bp_req0_ready", int'(r0_rdy[0]), 0);
      chk("bp_req1_ready", int'(r1_rdy[0]), 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    drive(0, 1, 1'b0, 3'b000, 8'h00, 8'h00);
    rsp_rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_busy", int'(busy[0]), 0);
    chk("bp_release_rsp_valid", int'(rsp_v[0]), 0);
    chk("bp_hold_alu_operand1", int'(alu_a[0]), 8'hA0);

    // settle parameter 3: FWD 7E
    push_exp(1, 1'b0, 8'h7E, 1'b0);
    drive(1, 0, 1'b1, 3'b000, 8'h7E, 8'h00);
    wait_hs(1, 1);
    drive(1, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    wait_idle(1);

    // reset mid-operation on a port 0 request
    drive(1, 0, 1'b1, 3'b001, 8'h01, 8'h01);
    wait_hs(1, 2);
    drive(1, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("midop_busy_before", int'(busy[1]), 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals(1, "midop");
    hs_q1.delete();
    #10 reset = 1'b0;
    @(posedge clk); #1;
    push_exp(1, 1'b0, 8'h55, 1'b0);
    drive(1, 0, 1'b1, 3'b000, 8'h55, 8'h00);
    drive(1, 1, 1'b1, 3'b000, 8'h66, 8'h00);
    wait_hs(1, 3);
    drive(1, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    drive(1, 1, 1'b0, 3'b000, 8'h00, 8'h00);
    wait_idle(1);

    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that shares the single 8-bit ALU between two requesters: the instruction-decode path (port 0) and an auxiliary unit (port 1). It arbitrates valid/ready requests and registers the granted operands and opcode onto the ALU inputs. It waits a fixed settle time, then captures the result and zero flag into a held response buffer. It sits between the requesters and the ALU instance in the CPU datapath.

## Interface
- SETTLE_CYCLES, 1: clock edges from issue to result capture; legal range 1..15.
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- REQ0_VALID / REQ1_VALID  input  1  request present.
- REQ0_READY / REQ1_READY  output  1  request accepted this cycle when VALID&READY.
- REQ0_OPERAND1, REQ0_OPERAND2, REQ1_OPERAND1, REQ1_OPERAND2  input  8  operands.
- REQ0_ALU_OP / REQ1_ALU_OP  input  3  ALU opcode: 000 FWD, 001 ADD, 010 OR, 011 AND.
- ALU_OPERAND1 / ALU_OPERAND2  output  8  registered ALU inputs.
- ALU_OP  output  3  registered ALU opcode.
- ALU_RESULT  input  8  ALU output.
- ALU_ZERO  input  1  ALU zero (comparator) output.
- RSP_VALID  output  1  response held.
- RSP_READY  input  1  consumer takes response.
- RSP_ID  output  1  requester that owns the response.
- RSP_RESULT  output  8  captured result.
- RSP_ZERO  output  1  captured zero flag.
- BUSY  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: grant chosen combinationally from the VALIDs; only the granted port sees READY=1, and READY=0 in every other state. On handshake, latch operands and opcode into the ALU_* registers, record the grant in RSP_ID, load the settle counter with SETTLE_CYCLES-1, and go to WAIT.
- WAIT: decrement the counter. At the edge where the counter is 0, capture ALU_RESULT into RSP_RESULT and ALU_ZERO into RSP_ZERO, set RSP_VALID, and go to RESP.
- RESP: hold all RSP_* outputs stable until RSP_VALID&RSP_READY. On that edge, clear RSP_VALID and return to IDLE. No new grant happens in the same cycle; there is one bubble cycle.
- ALU_* registers hold their last value after issue; they are not cleared on return to IDLE.
- Opcodes 1xx are accepted and forwarded unchanged. The ALU returns 0, so the response is RESULT=0, ZERO=1.
- Requesters keep VALID and payload stable until accepted. The arbiter does not sample the payload outside the handshake.
- Arbitration with both VALIDs high: see Configuration. A single VALID is always granted.
- RESET asserted in any state: FSM goes to IDLE immediately; any pending response is discarded.

## Timing
- Handshake accepted at edge N. ALU inputs are valid after edge N. Result is captured at edge N+SETTLE_CYCLES. RSP_VALID is high from edge N+SETTLE_CYCLES.
- Minimum spacing between issues is SETTLE_CYCLES+2 edges: WAIT, RESP with RSP_READY already high, then the IDLE bubble.
- SETTLE_CYCLES×clock period must exceed the worst ALU path (ADD, 2 ns plus mux).
- REQx_READY is combinational from the state, both VALIDs and the priority pointer. It is valid the same cycle VALID rises.
- Reset values: state IDLE; REQ0_READY=REQ1_READY=0 while RESET is high; ALU_OPERAND1=ALU_OPERAND2=0; ALU_OP=000; RSP_VALID=0; RSP_ID=0; RSP_RESULT=0; RSP_ZERO=0; BUSY=0; priority pointer LAST_GRANT=1, so port 0 wins first.

## Configuration
- ALU_SHARE_RR_EN defined: round-robin arbitration. With both ports valid, grant the port other than LAST_GRANT. LAST_GRANT updates on each handshake.
- ALU_SHARE_RR_EN undefined: fixed priority, port 0 always wins. The LAST_GRANT register is not built.

## Structure
- Shared package/header alu_defs: ALU opcode constants (ALU_FWD=3'b000, ALU_ADD=3'b001, ALU_OR=3'b010, ALU_AND=3'b011) and FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2). The ALU and the decoder also use the opcode constants.
- One sub-module: alu_share_grant. It holds the combinational grant logic plus the LAST_GRANT register, and is the only place ALU_SHARE_RR_EN is tested.
- The ALU itself is instantiated outside this block, by the parent.

## Test plan
- Single request: after reset, port 0 issues ADD 8'h05+8'h03 with SETTLE_CYCLES=1 and RSP_READY=1 -> RSP_VALID rises 1 edge after the handshake; RSP_ID=0, RSP_RESULT=8'h08, RSP_ZERO=0.
- Zero flag: port 1 issues AND 8'hF0&8'h0F -> RSP_ID=1, RSP_RESULT=8'h00, RSP_ZERO=1.
- Contention: both ports hold VALID through 4 issues -> with ALU_SHARE_RR_EN, grants go 0,1,0,1; without it, grants go 0,0,0,0 and port 1 stays READY=0.
- Backpressure: RSP_READY=0 for 5 cycles after capture of OR 8'hA0|8'h0A -> RSP_VALID and RSP_RESULT=8'hAA stay stable, BUSY=1, both READY=0; release -> IDLE one edge later.
- Settle parameter: SETTLE_CYCLES=3 with FWD 8'h7E -> capture exactly 3 edges after the handshake; RSP_RESULT=8'h7E.
- Reset mid-op: assert RESET during WAIT -> all outputs at reset values asynchronously, with no response emitted; the next request after deassert is granted to port 0.
